inst_fetch_queue: RTL and testbench

Instruction fetch front end that produces the 32-bit instruction words consumed by the decoder. It fetches bytes over the byte-wide memory-controller port and assembles them little-endian. Completed words are buffered with their PC in a small circular queue. It presents one {pc, instruction} entry per cycle to the decode stage, and branch or jump redirects flush it.

---
 rtl/inst_fetch_queue.sv | 265 ++++++++++++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end. It reads bytes over the byte-wide memory port
// and assembles them little-endian into 32-bit words. Completed words are kept
// with their PC in a circular queue that feeds the decode stage.
// Optional feature macro: FETCH_OPCHECK_EN. When it is defined, each word is
// checked against the supported opcodes on push, and inst_illegal is driven
// from the head entry.
module inst_fetch_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_din,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_illegal
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Fetch engine state
  logic [31:0] r_fetch_pc;
  logic [2:0]  r_issue_cnt;
  logic [1:0]  r_recv_cnt;
  logic [23:0] r_asm;
  logic [7:0]  r_last;
  logic        r_word_rdy;
  logic        r_pend;
  logic        r_drop;

  // Queue storage and pointers
  logic [31:0]      r_q_word [QUEUE_DEPTH];
  logic [31:0]      r_q_pc   [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Registered head view
  logic        r_inst_valid;
  logic [31:0] r_inst_out;
  logic [31:0] r_inst_pc;

  logic             w_redirect;
  logic             w_issue;
  logic             w_grant;
  logic             w_cap;
  logic             w_cap_last;
  logic             w_push;
  logic             w_pop;
  logic             w_enter;
  logic [31:0]      w_push_word;
  logic [PTR_W-1:0] w_head_nxt;
  logic [PTR_W-1:0] w_tail_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_head_from_push;
  logic [31:0]      w_head_word;
  logic [31:0]      w_head_pc;

  // Request, capture, push and pop qualifiers
  always_comb begin
    w_redirect  = jump_en & rdy_in;
    w_issue     = (r_state == S_FETCH) & rdy_in & ~jump_en & (r_issue_cnt < 3'd4);
    w_grant     = w_issue & mem_gnt;
    // Memory never stalls its return, so a byte is captured even when paused;
    // a redirect in the landing cycle discards it.
    w_cap       = r_pend & ~r_drop & ~w_redirect;
    w_cap_last  = w_cap & (r_recv_cnt == 2'd3);
    w_push      = (w_cap_last | r_word_rdy) & rdy_in & ~jump_en;
    w_pop       = r_inst_valid & inst_ready & rdy_in & ~jump_en;
    w_enter     = (r_state == S_IDLE) & (w_state_nxt == S_FETCH);
    w_push_word = r_word_rdy ? {r_last, r_asm} : {mem_din, r_asm};
  end

  assign mem_req  = w_issue;
  assign mem_addr = r_fetch_pc + 32'(r_issue_cnt);

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: fetch a word whenever a queue slot is free
  always_comb begin
    w_state_nxt = r_state;
    if (rdy_in) begin
      if (jump_en) begin
        w_state_nxt = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:  if (r_count < CNT_W'(QUEUE_DEPTH)) w_state_nxt = S_FETCH;
          S_FETCH: if (w_push) w_state_nxt = S_IDLE;
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Fetch engine: issue counting, byte assembly and PC advance
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fetch_pc  <= RESET_PC;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_asm       <= '0;
      r_last      <= '0;
      r_word_rdy  <= 1'b0;
      r_pend      <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_pend <= w_grant;
      r_drop <= w_redirect & r_pend;
      if (w_redirect) begin
        r_fetch_pc  <= jump_pc;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
        r_word_rdy  <= 1'b0;
      end else begin
        if (w_enter) begin
          r_issue_cnt <= '0;
          r_recv_cnt  <= '0;
        end else begin
          if (w_grant) r_issue_cnt <= r_issue_cnt + 3'd1;
          if (w_cap) begin
            r_recv_cnt <= r_recv_cnt + 2'd1;
            case (r_recv_cnt)
              2'd0: r_asm[7:0]   <= mem_din;
              2'd1: r_asm[15:8]  <= mem_din;
              2'd2: r_asm[23:16] <= mem_din;
              default: begin
                // Last byte landed while paused: hold it until the push can go
                if (!w_push) begin
                  r_last     <= mem_din;
                  r_word_rdy <= 1'b1;
                end
              end
            endcase
          end
        end
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_word_rdy <= 1'b0;
        end
      end
    end
  end

  // Queue pointer and occupancy next state; redirect flushes everything
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (w_redirect) begin
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      if (w_push) w_tail_nxt = r_tail + PTR_W'(1);
      if (w_pop)  w_head_nxt = r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Next head entry, bypassing the entry being written when it becomes head
  always_comb begin
    w_head_from_push = w_push & (r_tail == w_head_nxt);
    w_head_word      = w_head_from_push ? w_push_word : r_q_word[w_head_nxt];
    w_head_pc        = w_head_from_push ? r_fetch_pc  : r_q_pc[w_head_nxt];
  end

  // Queue storage write
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_q_word[r_tail] <= w_push_word;
      r_q_pc[r_tail]   <= r_fetch_pc;
    end
  end

  // Queue pointers and registered head view (zero while empty)
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_inst_valid <= 1'b0;
      r_inst_out   <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_count      <= w_count_nxt;
      r_inst_valid <= (w_count_nxt != '0);
      r_inst_out   <= (w_count_nxt != '0) ? w_head_word : 32'h0;
      r_inst_pc    <= (w_count_nxt != '0) ? w_head_pc   : 32'h0;
    end
  end

  assign inst_valid = r_inst_valid;
  assign inst_out   = r_inst_out;
  assign inst_pc    = r_inst_pc;

`ifdef FETCH_OPCHECK_EN
  logic r_q_ill [QUEUE_DEPTH];
  logic r_inst_ill;
  logic w_push_ill;
  logic w_head_ill;

  function automatic logic op_illegal(input logic [6:0] op);
    case (op)
      7'b0010011, 7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011: op_illegal = 1'b0;
      default:                                        op_illegal = 1'b1;
    endcase
  endfunction

  // Opcode classification of the word being pushed and of the next head
  always_comb begin
    w_push_ill = op_illegal(w_push_word[6:0]);
    w_head_ill = w_head_from_push ? w_push_ill : r_q_ill[w_head_nxt];
  end

  // Illegal flag stored alongside each entry
  always_ff @(posedge clk_in) begin
    if (w_push) r_q_ill[r_tail] <= w_push_ill;
  end

  // Registered illegal flag of the head entry
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_inst_ill <= 1'b0;
    end else begin
      r_inst_ill <= (w_count_nxt != '0) ? w_head_ill : 1'b0;
    end
  end

  assign inst_illegal = r_inst_ill;
`else
  assign inst_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a byte memory model answers granted
// requests, stimulus pushes expected {pc, word, illegal} entries, and a monitor
// compares every entry the decode side accepts.
module tb_inst_fetch_queue;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic        jump_en;
  logic [31:0] jump_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic        tb_g;
  logic [31:0] tb_a;
  logic [31:0] exp_a;

  inst_fetch_queue #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_din     (mem_din),
    .jump_en     (jump_en),
    .jump_pc     (jump_pc),
    .inst_ready  (inst_ready),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_illegal(inst_illegal)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Memory image: a few hand-picked words, distinct bytes elsewhere
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    case (pc)
      32'h0000_0000: word_at = 32'h00a00513;
      32'h0000_0600: word_at = 32'hffffffff;
      32'h0000_0604: word_at = 32'h0badc0de;
      default:       word_at = {pc[7:0] ^ 8'h3c, pc[15:8] ^ 8'hc5, pc[7:0] ^ 8'h96, 8'h13};
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    byte_at = w[8*a[1:0] +: 8];
  endfunction

  function automatic logic exp_ill(input logic [31:0] w);
`ifdef FETCH_OPCHECK_EN
    case (w[6:0])
      7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33: exp_ill = 1'b0;
      default: exp_ill = 1'b1;
    endcase
`else
    exp_ill = 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = word_at(pc);
    e.ill  = exp_ill(e.word);
    exp_q.push_back(e);
  endtask

  task automatic next_cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) next_cyc();
  endtask

  // Accept exactly n entries, then drop inst_ready
  task automatic pop_n(input int n);
    int got;
    int guard;
    got   = 0;
    guard = 0;
    next_cyc();
    inst_ready = 1'b1;
    while (got < n && guard < 200) begin
      @(negedge clk_in);
      if (inst_valid && rdy_in) got++;
      next_cyc();
      guard++;
    end
    inst_ready = 1'b0;
    chk("pop_budget", 32'(got), 32'(n));
  endtask

  task automatic redirect(input logic [31:0] pc);
    next_cyc();
    jump_en = 1'b1;
    jump_pc = pc;
    next_cyc();
    jump_en = 1'b0;
  endtask

  // Memory model: a grant seen in one cycle returns its byte the next cycle
  always @(negedge clk_in) begin
    tb_g = mem_req & mem_gnt;
    tb_a = mem_addr;
  end

  always begin
    @(posedge clk_in);
    #1;
    mem_din = tb_g ? byte_at(tb_a) : 8'hee;
  end

  // Monitor: compare each accepted head entry with the scoreboard
  always @(negedge clk_in) begin
    if (!rst_in && inst_valid && inst_ready && rdy_in) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h word %h expected no entry", inst_pc, inst_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", inst_pc, mon_e.pc);
        chk("sb_word", inst_out, mon_e.word);
        chk("sb_ill", 32'(inst_illegal), 32'(mon_e.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_g       = 1'b0;
    tb_a       = '0;
    mem_din    = 8'h00;
    rst_in     = 1'b1;
    rdy_in     = 1'b1;
    mem_gnt    = 1'b0;
    jump_en    = 1'b0;
    jump_pc    = '0;
    inst_ready = 1'b0;
    exp_a      = '0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in  = 1'b0;
    mem_gnt = 1'b1;

    // Cycle 0: reset state
    @(negedge clk_in);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_illegal", 32'(inst_illegal), 32'd0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    next_cyc();
    @(negedge clk_in);
    chk("c1_mem_req", 32'(mem_req), 32'd1);
    chk("c1_mem_addr", mem_addr, 32'h0);
    tick(4);
    @(negedge clk_in);
    chk("c5_valid", 32'(inst_valid), 32'd0);
    next_cyc();
    @(negedge clk_in);
    chk("c6_valid", 32'(inst_valid), 32'd1);
    chk("c6_inst_out", inst_out, 32'h00a00513);
    chk("c6_inst_pc", inst_pc, 32'h0);
    chk("c6_illegal", 32'(inst_illegal), 32'd0);

    // Queue fills to four entries, then fetch stops
    tick(18);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      chk("full_no_req", 32'(mem_req), 32'd0);
      next_cyc();
    end
    push_exp(32'h0);
    inst_ready = 1'b1;
    next_cyc();
    inst_ready = 1'b0;
    @(negedge clk_in);
    chk("pop_req_t1", 32'(mem_req), 32'd0);
    next_cyc();
    @(negedge clk_in);
    chk("pop_req_t2", 32'(mem_req), 32'd1);
    chk("pop_addr_t2", mem_addr, 32'h10);

    // Redirect after two bytes granted
    next_cyc();
    next_cyc();
    jump_en = 1'b1;
    jump_pc = 32'h100;
    @(negedge clk_in);
    chk("jmp_no_req", 32'(mem_req), 32'd0);
    next_cyc();
    jump_en = 1'b0;
    @(negedge clk_in);
    chk("jmp_valid_low", 32'(inst_valid), 32'd0);
    chk("jmp_out_zero", inst_out, 32'h0);
    next_cyc();
    @(negedge clk_in);
    chk("jmp_req", 32'(mem_req), 32'd1);
    chk("jmp_addr", mem_addr, 32'h100);
    push_exp(32'h100);
    pop_n(1);

    // Alternating grants: address advances only on granted cycles
    redirect(32'h200);
    exp_a = 32'h200;
    for (int i = 0; i < 40; i++) begin
      mem_gnt = (i % 2 == 0);
      @(negedge clk_in);
      if (mem_req) begin
        chk("alt_addr", mem_addr, exp_a);
        if (mem_gnt) exp_a = exp_a + 32'd1;
      end
      next_cyc();
    end
    mem_gnt = 1'b1;
    chk("alt_progress", 32'(exp_a >= 32'h208), 32'd1);
    push_exp(32'h200);
    push_exp(32'h204);
    pop_n(2);

    // Simultaneous push and pop at count 2 leaves count at 2
    redirect(32'h300);
    tick(17);
    push_exp(32'h300);
    inst_ready = 1'b1;
    next_cyc();
    inst_ready = 1'b0;
    tick(7);
    @(negedge clk_in);
    chk("pp_req", 32'(mem_req), 32'd1);
    chk("pp_addr", mem_addr, 32'h310);
    tick(6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("pp_full_no_req", 32'(mem_req), 32'd0);
      next_cyc();
    end
    push_exp(32'h304);
    push_exp(32'h308);
    push_exp(32'h30c);
    push_exp(32'h310);
    pop_n(4);

    // Pause mid-fetch: pending byte kept, no duplicate or skipped address
    redirect(32'h400);
    next_cyc();
    @(negedge clk_in);
    chk("stall_addr0", mem_addr, 32'h400);
    next_cyc();
    @(negedge clk_in);
    chk("stall_addr1", mem_addr, 32'h401);
    next_cyc();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("stall_no_req", 32'(mem_req), 32'd0);
      next_cyc();
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("stall_resume_req", 32'(mem_req), 32'd1);
    chk("stall_resume_addr", mem_addr, 32'h402);
    push_exp(32'h400);
    pop_n(1);

    // Pause exactly when the last byte lands: word pushed once resumed
    redirect(32'h500);
    tick(5);
    rdy_in = 1'b0;
    next_cyc();
    @(negedge clk_in);
    chk("last_stall_valid", 32'(inst_valid), 32'd0);
    next_cyc();
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("last_resume_valid0", 32'(inst_valid), 32'd0);
    next_cyc();
    @(negedge clk_in);
    chk("last_resume_valid1", 32'(inst_valid), 32'd1);
    chk("last_resume_pc", inst_pc, 32'h500);
    push_exp(32'h500);
    pop_n(1);

    // Opcode check on 0xffffffff and 0x0badc0de
    redirect(32'h600);
    push_exp(32'h600);
    push_exp(32'h604);
    pop_n(2);

    tick(3);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
